// File: rtl/mc_pkg.sv
// Shared memory-controller types and widths.
// Used by the read-return path, the bank controller and benches.
package mc_pkg;

    localparam int MC_TAG_W     = 4;
    localparam int MC_RD_DATA_W = 128;
    localparam int MC_RD_DEPTH  = 2 ** MC_TAG_W;

    typedef logic [MC_TAG_W-1:0] rd_tag_t;

    typedef struct packed {
        logic                    valid;
        rd_tag_t                 tag;
        logic [MC_RD_DATA_W-1:0] data;
    } rd_ret_t;

endpackage

// File: rtl/mc_rd_return_if.sv
// Decoder-alloc, bank-return and system-delivery signals of the
// read-return reorder buffer.
interface mc_rd_return_if
    import mc_pkg::*;
#(
    parameter int TAG_W  = MC_TAG_W,
    parameter int DATA_W = MC_RD_DATA_W
);

    logic              dec__rdr__alloc_valid;
    logic [TAG_W-1:0]  rdr__dec__alloc_tag;
    logic              rdr__dec__alloc_ready;

    logic              bnc__rdr__valid;
    logic [TAG_W-1:0]  bnc__rdr__tag;
    logic [DATA_W-1:0] bnc__rdr__data;

    logic [DATA_W-1:0] mc__sys__dram_rd_data;
    logic              mc__sys__dram_rd_done;
    logic [TAG_W:0]    rdr__outstanding;
    logic              rdr__err;

    modport slave (
        input  dec__rdr__alloc_valid,
        output rdr__dec__alloc_tag,
        output rdr__dec__alloc_ready,
        input  bnc__rdr__valid,
        input  bnc__rdr__tag,
        input  bnc__rdr__data,
        output mc__sys__dram_rd_data,
        output mc__sys__dram_rd_done,
        output rdr__outstanding,
        output rdr__err
    );

    modport master (
        output dec__rdr__alloc_valid,
        input  rdr__dec__alloc_tag,
        input  rdr__dec__alloc_ready,
        output bnc__rdr__valid,
        output bnc__rdr__tag,
        output bnc__rdr__data,
        input  mc__sys__dram_rd_data,
        input  mc__sys__dram_rd_done,
        input  rdr__outstanding,
        input  rdr__err
    );

endinterface

// File: rtl/mc_rd_return_ram.sv
// Flop-based reorder storage: one write port for returns,
// one asynchronous read port at the head entry.
module mc_rd_return_ram #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [TAG_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [TAG_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**TAG_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mc_rd_return.sv
// Read-data reorder buffer: tags reads in issue order, accepts
// out-of-order returns and delivers to the system in order.
module mc_rd_return
    import mc_pkg::*;
#(
    parameter int TAG_W  = MC_TAG_W,
    parameter int DATA_W = MC_RD_DATA_W
) (
    input  logic clk,
    input  logic reset,
    mc_rd_return_if.slave bus
);

    localparam int DEPTH = 2 ** TAG_W;
    localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  alloc_q, alloc_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              alloc_ready;
    logic              alloc_fire;
    logic              deliver;
    logic              ret_ok;
    logic [DATA_W-1:0] head_data;

    mc_rd_return_ram #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ret_ok),
        .waddr_i (bus.bnc__rdr__tag),
        .wdata_i (bus.bnc__rdr__data),
        .raddr_i (head_q),
        .rdata_o (head_data)
    );

    always_comb begin
        alloc_ready = !reset && (count_q != CNT_FULL);
        alloc_fire  = bus.dec__rdr__alloc_valid && alloc_ready;
        deliver     = valid_q[head_q];
        // The head entry is already valid while delivering, so a
        // return aimed at it falls out as a duplicate here.
        ret_ok      = bus.bnc__rdr__valid
                   && alloc_q[bus.bnc__rdr__tag]
                   && !valid_q[bus.bnc__rdr__tag];

        head_d  = head_q;
        tail_d  = tail_q;
        alloc_d = alloc_q;
        valid_d = valid_q;
        done_d  = deliver;
        rdata_d = rdata_q;
        count_d = count_q;
        err_d   = err_q;

        if (deliver) begin
            alloc_d[head_q] = 1'b0;
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
            rdata_d         = head_data;
        end
        if (alloc_fire) begin
            alloc_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_ONE;
        end
        if (ret_ok) begin
            valid_d[bus.bnc__rdr__tag] = 1'b1;
        end

        unique case ({alloc_fire, deliver})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (bus.dec__rdr__alloc_valid && !alloc_ready) begin
            err_d = 1'b1;
        end
        if (bus.bnc__rdr__valid && !ret_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.rdr__dec__alloc_tag   = tail_q;
    assign bus.rdr__dec__alloc_ready = alloc_ready;
    assign bus.mc__sys__dram_rd_data = rdata_q;
    assign bus.mc__sys__dram_rd_done = done_q;
    assign bus.rdr__outstanding      = count_q;
    assign bus.rdr__err              = err_q;

endmodule

// File: tb/tb_mc_rd_return.sv
// Directed bench for the read-return reorder buffer.
module tb_mc_rd_return;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mc_rd_return_if bus ();

    mc_rd_return dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] dat(int n);
        return {4{32'hD00D_0000 + 32'(n)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs,
                       logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic do_alloc(int n);
        for (int i = 0; i < n; i++) begin
            bus.dec__rdr__alloc_valid = 1'b1;
            tick();
        end
        bus.dec__rdr__alloc_valid = 1'b0;
    endtask

    task automatic ret(int tag, logic [127:0] d);
        rd_ret_t r;
        r = '{valid: 1'b1, tag: rd_tag_t'(tag), data: d};
        bus.bnc__rdr__valid = r.valid;
        bus.bnc__rdr__tag   = r.tag;
        bus.bnc__rdr__data  = r.data;
        tick();
        bus.bnc__rdr__valid = 1'b0;
    endtask

    task automatic rst1();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_out(string tag, logic done,
                           logic [127:0] d);
        chk({tag, "_done"}, bus.mc__sys__dram_rd_done, done);
        if (done) chk({tag, "_data"}, bus.mc__sys__dram_rd_data, d);
    endtask

    initial begin
        bus.dec__rdr__alloc_valid = 1'b0;
        bus.bnc__rdr__valid       = 1'b0;
        bus.bnc__rdr__tag         = '0;
        bus.bnc__rdr__data        = '0;

        // reset state
        tick();
        tick();
        chk("rst_ready", bus.rdr__dec__alloc_ready, 0);
        chk("rst_out", bus.rdr__outstanding, 0);
        chk("rst_done", bus.mc__sys__dram_rd_done, 0);
        chk("rst_data", bus.mc__sys__dram_rd_data, 0);
        chk("rst_err", bus.rdr__err, 0);
        chk("rst_tag", bus.rdr__dec__alloc_tag, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", bus.rdr__dec__alloc_ready, 1);

        // in-order: tags 0..2
        do_alloc(3);
        chk("io_out3", bus.rdr__outstanding, 3);
        chk("io_tag", bus.rdr__dec__alloc_tag, 3);
        ret(0, dat(10));
        chk_out("io_t0", 0, 0);
        ret(1, dat(11));
        chk_out("io_d0", 1, dat(10));
        chk("io_out2", bus.rdr__outstanding, 2);
        ret(2, dat(12));
        chk_out("io_d1", 1, dat(11));
        chk("io_out1", bus.rdr__outstanding, 1);
        tick();
        chk_out("io_d2", 1, dat(12));
        chk("io_out0", bus.rdr__outstanding, 0);
        tick();
        chk_out("io_idle", 0, 0);
        chk("io_hold", bus.mc__sys__dram_rd_data, dat(12));

        // out-of-order: tags 3..6 returned 6,4,5,3
        do_alloc(4);
        chk("oo_out4", bus.rdr__outstanding, 4);
        ret(6, dat(26));
        chk_out("oo_w6", 0, 0);
        ret(4, dat(24));
        chk_out("oo_w4", 0, 0);
        ret(5, dat(25));
        chk_out("oo_w5", 0, 0);
        ret(3, dat(23));
        chk_out("oo_w3", 0, 0);
        tick();
        chk_out("oo_d3", 1, dat(23));
        tick();
        chk_out("oo_d4", 1, dat(24));
        tick();
        chk_out("oo_d5", 1, dat(25));
        tick();
        chk_out("oo_d6", 1, dat(26));
        chk("oo_out0", bus.rdr__outstanding, 0);
        tick();
        chk_out("oo_end", 0, 0);
        chk("oo_err", bus.rdr__err, 0);

        // simultaneous alloc + deliver: tags 7..11, head 7
        do_alloc(5);
        ret(7, dat(37));
        chk("sim_out5a", bus.rdr__outstanding, 5);
        bus.dec__rdr__alloc_valid = 1'b1;
        tick();
        bus.dec__rdr__alloc_valid = 1'b0;
        chk_out("sim_d7", 1, dat(37));
        chk("sim_out5b", bus.rdr__outstanding, 5);
        chk("sim_tail", bus.rdr__dec__alloc_tag, 13);
        ret(8, dat(38));
        chk_out("sim_w8", 0, 0);
        ret(9, dat(39));
        chk_out("sim_d8", 1, dat(38));
        ret(10, dat(40));
        chk_out("sim_d9", 1, dat(39));
        ret(11, dat(41));
        chk_out("sim_d10", 1, dat(40));
        ret(12, dat(42));
        chk_out("sim_d11", 1, dat(41));
        tick();
        chk_out("sim_d12", 1, dat(42));
        chk("sim_out0", bus.rdr__outstanding, 0);
        chk("sim_err", bus.rdr__err, 0);

        // unallocated tag 7
        ret(7, dat(99));
        chk("ua_err", bus.rdr__err, 1);
        chk("ua_out", bus.rdr__outstanding, 0);
        chk("ua_tag", bus.rdr__dec__alloc_tag, 13);
        tick();
        chk_out("ua_nodone", 0, 0);

        // reset mid-operation: tags 13,14,15,0
        do_alloc(4);
        chk("rm_wrap", bus.rdr__dec__alloc_tag, 1);
        ret(14, dat(54));
        ret(15, dat(55));
        chk("rm_out4", bus.rdr__outstanding, 4);
        reset = 1'b1;
        tick();
        chk("rm_out", bus.rdr__outstanding, 0);
        chk("rm_done", bus.mc__sys__dram_rd_done, 0);
        chk("rm_tag", bus.rdr__dec__alloc_tag, 0);
        chk("rm_err", bus.rdr__err, 0);
        chk("rm_ready", bus.rdr__dec__alloc_ready, 0);
        reset = 1'b0;
        ret(1, dat(61));
        chk("rm_old_err", bus.rdr__err, 1);
        tick();
        chk_out("rm_nodone", 0, 0);

        // duplicate return keeps first data
        rst1();
        do_alloc(2);
        ret(1, dat(71));
        chk("dup_err0", bus.rdr__err, 0);
        ret(1, dat(72));
        chk("dup_err1", bus.rdr__err, 1);
        ret(0, dat(70));
        chk_out("dup_w0", 0, 0);
        tick();
        chk_out("dup_d0", 1, dat(70));
        tick();
        chk_out("dup_d1", 1, dat(71));
        chk("dup_out0", bus.rdr__outstanding, 0);

        // full and wrap
        rst1();
        do_alloc(16);
        chk("full_ready", bus.rdr__dec__alloc_ready, 0);
        chk("full_out", bus.rdr__outstanding, 16);
        chk("full_tag", bus.rdr__dec__alloc_tag, 0);
        chk("full_err0", bus.rdr__err, 0);
        do_alloc(1);
        chk("full_err1", bus.rdr__err, 1);
        chk("full_out2", bus.rdr__outstanding, 16);
        ret(0, dat(80));
        chk_out("full_w0", 0, 0);
        tick();
        chk_out("full_d0", 1, dat(80));
        chk("full_out15", bus.rdr__outstanding, 15);
        chk("wrap_ready", bus.rdr__dec__alloc_ready, 1);
        chk("wrap_tag", bus.rdr__dec__alloc_tag, 0);
        do_alloc(1);
        chk("wrap_out16", bus.rdr__outstanding, 16);
        chk("wrap_tag1", bus.rdr__dec__alloc_tag, 1);
        chk("wrap_ready0", bus.rdr__dec__alloc_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
